// File: rtl/sd_sector_writer_pkg.sv
// Shared state, result and token codes for the SD DAT0 sector write path.
package sd_sector_writer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_PRE   = 4'd1,
    ST_START = 4'd2,
    ST_DATA  = 4'd3,
    ST_CRC   = 4'd4,
    ST_END   = 4'd5,
    ST_STAT  = 4'd6,
    ST_BUSY  = 4'd7,
    ST_FIN   = 4'd8
  } state_t;

  localparam logic [1:0] WSTAT_OK      = 2'd0;
  localparam logic [1:0] WSTAT_CRC_ERR = 2'd1;
  localparam logic [1:0] WSTAT_BAD_TOK = 2'd2;
  localparam logic [1:0] WSTAT_TIMEOUT = 2'd3;

  localparam logic [2:0] TOK_ACCEPT  = 3'b010;
  localparam logic [2:0] TOK_CRC_ERR = 3'b101;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16-CCITT (x^16+x^12+x^5+1), init 0, shared by the write and read paths.
module sd_crc16
  import sd_sector_writer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  assign fb = din ^ crc[15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      crc <= '0;
    else if (clr)
      crc <= '0;
    else if (en)
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  end

endmodule

// File: rtl/sd_sector_writer.sv
// DAT0 transmit path: frames one 512-byte sector with CRC16, then checks the
// card's CRC-status token and waits out busy. Runs in clk with sdclk edge detect.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for wstart, line released
// ST_PRE   | driving PRE_BITS ones ahead of the start bit
// ST_START | driving the start bit, first byte loaded into shifter
// ST_DATA  | shifting out 4096 data bits MSB-first into the CRC
// ST_CRC   | driving the frozen CRC16, MSB-first
// ST_END   | end bit, then release of the line on the following fall
// ST_STAT  | sampling start bit, 3-bit status token and end bit
// ST_BUSY  | waiting for the card to release DAT0
// ST_FIN   | wdone pulse, back to idle
module sd_sector_writer
  import sd_sector_writer_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 1000000,
  parameter int PRE_BITS     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdclk,
  output logic       sddat0_oe,
  output logic       sddat0_out,
  input  logic       sddat0_in,
  input  logic       wstart,
  output logic       wbusy,
  output logic       wdone,
  output logic [1:0] wstat,
  output logic       inreq,
  output logic [8:0] inaddr,
  input  logic [7:0] inbyte
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_t        state, state_n;
  logic          sdclkl, fall, rise;
  logic          oe_n, out_n, wbusy_n, wdone_n, inreq_n;
  logic [1:0]    wstat_n;
  logic [8:0]    inaddr_n;
  logic [7:0]    sh, sh_n, prefetch;
  logic          fetch_pend;
  logic [11:0]   cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    tok, tok_n;
  logic [9:0]    next_addr;
  logic          crc_clr, crc_en, fin;
  logic [1:0]    fin_code;
  logic [15:0]   crc;

  assign fall = sdclkl & ~sdclk;
  assign rise = ~sdclkl & sdclk;

  sd_crc16 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (sh[7]),
    .crc (crc)
  );

  always_comb begin
    state_n   = state;
    oe_n      = sddat0_oe;
    out_n     = sddat0_out;
    sh_n      = sh;
    cnt_n     = cnt;
    tcnt_n    = tcnt;
    tok_n     = tok;
    wstat_n   = wstat;
    wbusy_n   = wbusy;
    wdone_n   = 1'b0;
    inreq_n   = 1'b0;
    inaddr_n  = inaddr;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    fin       = 1'b0;
    fin_code  = WSTAT_OK;
    next_addr = {1'b0, cnt[11:3]} + 10'd2;

    case (state)
      ST_IDLE: if (wstart) begin
        state_n  = ST_PRE;
        wbusy_n  = 1'b1;
        inreq_n  = 1'b1;
        inaddr_n = 9'd0;
        crc_clr  = 1'b1;
        cnt_n    = 12'(PRE_BITS - 1);
      end
      ST_PRE: if (fall) begin
        oe_n  = 1'b1;
        out_n = 1'b1;
        if (cnt == 12'd0) state_n = ST_START;
        else              cnt_n   = cnt - 12'd1;
      end
      ST_START: if (fall) begin
        out_n    = 1'b0;
        sh_n     = prefetch;
        inreq_n  = 1'b1;
        inaddr_n = 9'd1;
        cnt_n    = 12'd0;
        state_n  = ST_DATA;
      end
      ST_DATA: if (fall) begin
        out_n  = sh[7];
        crc_en = 1'b1;
        sh_n   = {sh[6:0], 1'b0};
        // last bit of a byte: swap in the prefetched byte and fetch two ahead
        if (cnt[2:0] == 3'd7) begin
          sh_n = prefetch;
          if (next_addr <= 10'd511) begin
            inreq_n  = 1'b1;
            inaddr_n = next_addr[8:0];
          end
        end
        if (cnt == 12'd4095) begin
          state_n = ST_CRC;
          cnt_n   = 12'd0;
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      ST_CRC: if (fall) begin
        out_n = crc[4'd15 - cnt[3:0]];
        if (cnt[3:0] == 4'd15) begin
          state_n = ST_END;
          cnt_n   = 12'd0;
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      ST_END: if (fall) begin
        out_n = 1'b1;
        if (cnt == 12'd0) begin
          cnt_n = 12'd1;
        end else begin
          oe_n    = 1'b0;
          cnt_n   = 12'd0;
          tcnt_n  = TW'(BUSY_TIMEOUT);
          state_n = ST_STAT;
        end
      end
      ST_STAT: if (rise) begin
        if (tcnt == '0) begin
          fin      = 1'b1;
          fin_code = WSTAT_TIMEOUT;
        end else begin
          tcnt_n = tcnt - 1'b1;
          if (cnt == 12'd0) begin
            if (!sddat0_in) cnt_n = 12'd1;
          end else if (cnt < 12'd4) begin
            tok_n = {tok[1:0], sddat0_in};
            cnt_n = cnt + 12'd1;
          end else if (!sddat0_in || (tok != TOK_ACCEPT && tok != TOK_CRC_ERR)) begin
            fin      = 1'b1;
            fin_code = WSTAT_BAD_TOK;
          end else if (tok == TOK_CRC_ERR) begin
            fin      = 1'b1;
            fin_code = WSTAT_CRC_ERR;
          end else begin
            state_n = ST_BUSY;
          end
        end
      end
      ST_BUSY: if (rise) begin
        if (tcnt == '0) begin
          fin      = 1'b1;
          fin_code = WSTAT_TIMEOUT;
        end else begin
          tcnt_n = tcnt - 1'b1;
          if (sddat0_in) begin
            fin      = 1'b1;
            fin_code = WSTAT_OK;
          end
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    if (fin) begin
      state_n = ST_FIN;
      wdone_n = 1'b1;
      wbusy_n = 1'b0;
      wstat_n = fin_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sdclkl     <= 1'b0;
      sddat0_oe  <= 1'b0;
      sddat0_out <= 1'b1;
      sh         <= '0;
      prefetch   <= '0;
      fetch_pend <= 1'b0;
      cnt        <= '0;
      tcnt       <= '0;
      tok        <= '0;
      wstat      <= WSTAT_OK;
      wbusy      <= 1'b0;
      wdone      <= 1'b0;
      inreq      <= 1'b0;
      inaddr     <= '0;
    end else begin
      state      <= state_n;
      sdclkl     <= sdclk;
      sddat0_oe  <= oe_n;
      sddat0_out <= out_n;
      sh         <= sh_n;
      fetch_pend <= inreq;
      if (fetch_pend) prefetch <= inbyte;
      cnt        <= cnt_n;
      tcnt       <= tcnt_n;
      tok        <= tok_n;
      wstat      <= wstat_n;
      wbusy      <= wbusy_n;
      wdone      <= wdone_n;
      inreq      <= inreq_n;
      inaddr     <= inaddr_n;
    end
  end

endmodule

// File: tb/tb_sd_sector_writer.sv
// Directed bench for sd_sector_writer: table of full sector transfers against a
// card/RAM model, plus hand sequences for reset state and mid-transfer reset.
module tb_sd_sector_writer;

  logic       clk, rst, sdclk;
  logic       sddat0_oe, sddat0_out, sddat0_in;
  logic       wstart, wbusy, wdone, inreq;
  logic [1:0] wstat;
  logic [8:0] inaddr;
  logic [7:0] inbyte;
  logic       card_dat;

  int checks = 0;
  int errors = 0;

  assign sddat0_in = sddat0_oe ? sddat0_out : card_dat;

  sd_sector_writer #(.BUSY_TIMEOUT(1000), .PRE_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .sdclk      (sdclk),
    .sddat0_oe  (sddat0_oe),
    .sddat0_out (sddat0_out),
    .sddat0_in  (sddat0_in),
    .wstart     (wstart),
    .wbusy      (wbusy),
    .wdone      (wdone),
    .wstat      (wstat),
    .inreq      (inreq),
    .inaddr     (inaddr),
    .inbyte     (inbyte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial sdclk = 1'b0;
  always #10 sdclk = ~sdclk;

  typedef struct {
    int         pat;
    logic [2:0] tok;
    logic       end_ok;
    int         busy;      // busy rises before release, -1 = never releases
    logic [1:0] exp_stat;
    logic       use_const;
    logic [15:0] exp_crc;
  } vec_t;

  logic cap_q[$];
  int   req_q[$];
  logic card_q[$];
  logic seen_oe, end_phase, oe_bad, sdclk_prev, ram_pend;
  logic [7:0] ram_val;
  int   cur_pat, rise_cnt;
  time  t_last;

  function automatic logic [7:0] pat_byte(int p, int a);
    logic [7:0] lo;
    lo = a[7:0];
    case (p)
      0:       return 8'hFF;
      1:       return lo;
      default: return 8'((lo * 8'd7) ^ 8'h3C);
    endcase
  endfunction

  function automatic logic [15:0] crc_model(int p);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = '0;
    for (int a = 0; a < 512; a++) begin
      b = pat_byte(p, a);
      for (int k = 7; k >= 0; k--) begin
        fb = b[k] ^ c[15];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clk step: RAM model, bit capture on sdclk rise, card drive on sdclk fall.
  task automatic tick();
    @(negedge clk);
    #2;
    inbyte   = ram_pend ? ram_val : 8'hA5;
    ram_pend = 1'b0;
    if (inreq) begin
      req_q.push_back(int'(inaddr));
      ram_pend = 1'b1;
      ram_val  = pat_byte(cur_pat, int'(inaddr));
    end
    if (sdclk && !sdclk_prev) begin
      if (sddat0_oe) begin
        cap_q.push_back(sddat0_out);
        seen_oe = 1'b1;
      end else if (seen_oe) begin
        rise_cnt++;
      end
    end
    if (seen_oe && !sddat0_oe) end_phase = 1'b1;
    if (end_phase && sddat0_oe) oe_bad = 1'b1;
    if (!sdclk && sdclk_prev && end_phase && card_q.size() > 0) begin
      card_dat = card_q.pop_front();
      t_last   = $time;
    end
    sdclk_prev = sdclk;
  endtask

  task automatic clear_run();
    cap_q.delete();
    req_q.delete();
    card_q.delete();
    seen_oe   = 1'b0;
    end_phase = 1'b0;
    oe_bad    = 1'b0;
    rise_cnt  = 0;
    card_dat  = 1'b1;
    ram_pend  = 1'b0;
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int   n, mism, rises_at_done, viol;
    logic got;
    logic [1:0] stat_at_done;
    logic [7:0] b;
    logic [15:0] crc_cap;
    time  t_done;

    tbl[0] = '{0, 3'b010, 1'b1, 100, 2'd0, 1'b1, 16'h7FA1};
    tbl[1] = '{1, 3'b010, 1'b1,  -1, 2'd3, 1'b0, 16'h0000};
    tbl[2] = '{1, 3'b010, 1'b1,   3, 2'd0, 1'b0, 16'h0000};
    tbl[3] = '{2, 3'b101, 1'b1,   0, 2'd1, 1'b0, 16'h0000};
    tbl[4] = '{1, 3'b110, 1'b1,   0, 2'd2, 1'b0, 16'h0000};
    tbl[5] = '{0, 3'b010, 1'b0,   0, 2'd2, 1'b1, 16'h7FA1};

    rst = 1'b1; wstart = 1'b0; inbyte = 8'h00; sdclk_prev = 1'b0;
    ram_val = 8'h00; cur_pat = 0; t_last = 0;
    clear_run();
    repeat (3) tick();
    chk("rst_oe",     sddat0_oe,  1'b0);
    chk("rst_out",    sddat0_out, 1'b1);
    chk("rst_wbusy",  wbusy,      1'b0);
    chk("rst_wdone",  wdone,      1'b0);
    chk("rst_wstat",  wstat,      2'd0);
    chk("rst_inreq",  inreq,      1'b0);
    chk("rst_inaddr", inaddr,     9'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Reset in the middle of DATA while byte 100 is on the wire.
    cur_pat = 1;
    clear_run();
    wstart = 1'b1; tick(); wstart = 1'b0; tick();
    chk("midrst_busy", wbusy, 1'b1);
    n = 0;
    while (!(req_q.size() > 0 && req_q[$] == 101) && n < 5000) begin
      tick();
      n++;
    end
    chk("midrst_reqs", req_q.size(), 102);
    repeat (4) tick();
    chk("midrst_oe_before", sddat0_oe, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_oe",    sddat0_oe, 1'b0);
    chk("midrst_wbusy", wbusy,     1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      v = tbl[i];
      cur_pat = v.pat;
      clear_run();
      card_q.push_back(1'b1);
      card_q.push_back(1'b0);
      card_q.push_back(v.tok[2]);
      card_q.push_back(v.tok[1]);
      card_q.push_back(v.tok[0]);
      card_q.push_back(v.end_ok);
      if (v.end_ok && v.tok == 3'b010) begin
        if (v.busy < 0) begin
          card_q.push_back(1'b0);
        end else begin
          for (int k = 0; k < v.busy; k++) card_q.push_back(1'b0);
          card_q.push_back(1'b1);
        end
      end

      wstart = 1'b1; tick(); wstart = 1'b0; tick();
      chk($sformatf("v%0d_wbusy", i), wbusy, 1'b1);

      n = 0; got = 1'b0; t_done = 0; stat_at_done = 2'd0; rises_at_done = 0;
      while (!got && n < 20000) begin
        wstart = (n == 200);
        tick();
        n++;
        if (wdone) begin
          got           = 1'b1;
          t_done        = $time;
          stat_at_done  = wstat;
          rises_at_done = rise_cnt;
        end
      end
      chk($sformatf("v%0d_wdone_seen", i), got, 1'b1);

      // wstart during the wdone cycle must be ignored
      wstart = got;
      tick();
      wstart = 1'b0;
      viol = 0;
      repeat (20) begin
        tick();
        if (inreq || wbusy || wdone) viol++;
      end
      chk($sformatf("v%0d_idle_after", i), viol, 0);
      chk($sformatf("v%0d_wstat", i), stat_at_done, v.exp_stat);
      chk($sformatf("v%0d_wstat_held", i), wstat, v.exp_stat);
      chk($sformatf("v%0d_nbits", i), cap_q.size(), 4122);
      chk($sformatf("v%0d_nreq", i), req_q.size(), 512);
      chk($sformatf("v%0d_oe_after_end", i), oe_bad, 1'b0);

      mism = 0;
      for (int k = 0; k < req_q.size() && k < 512; k++)
        if (req_q[k] != k) mism++;
      chk($sformatf("v%0d_req_order", i), mism, 0);

      if (cap_q.size() >= 4122) begin
        mism = 0;
        for (int k = 0; k < 8; k++) if (cap_q[k] !== 1'b1) mism++;
        chk($sformatf("v%0d_pre_ones", i), mism, 0);
        chk($sformatf("v%0d_start_bit", i), cap_q[8], 1'b0);
        mism = 0;
        for (int a = 0; a < 512; a++) begin
          for (int k = 0; k < 8; k++) b[7-k] = cap_q[9 + 8*a + k];
          if (b !== pat_byte(v.pat, a)) mism++;
        end
        chk($sformatf("v%0d_data_bytes_bad", i), mism, 0);
        for (int k = 0; k < 16; k++) crc_cap[15-k] = cap_q[4105 + k];
        chk($sformatf("v%0d_crc_model", i), crc_cap, crc_model(v.pat));
        if (v.use_const) chk($sformatf("v%0d_crc_const", i), crc_cap, v.exp_crc);
        chk($sformatf("v%0d_end_bit", i), cap_q[4121], 1'b1);
      end

      if (got) begin
        if (v.busy < 0)
          chk($sformatf("v%0d_timeout_rises", i), rises_at_done, 1001);
        else
          chk_range($sformatf("v%0d_done_latency_ns", i), int'(t_done - t_last), 10, 30);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_sector_writer.md
Name: sd_sector_writer

Overview:
- DAT0 transmit path of the SD host: sends one 512-byte sector on DAT0 after the command controller has issued CMD24 and received R1.
- Frames the data block (start bit, 4096 data bits, CRC16, end bit), then checks the card's CRC-status token and waits out card busy.
- Uses the sdclk produced by the command controller; all logic runs in the clk domain using edge detection on sdclk.

Parameters:
- BUSY_TIMEOUT, 1000000, max sdclk rising edges allowed for the status-token wait plus the busy wait before reporting timeout.
- PRE_BITS, 8, number of '1' bits driven before the start bit (Nwr gap, minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sdclk  in  1  SD clock from the command controller, high/low each at least 1 clk
- sddat0_oe  out  1  DAT0 output enable, 1 = host drives
- sddat0_out  out  1  DAT0 drive value
- sddat0_in  in  1  DAT0 pin value, already synchronised
- wstart  in  1  one-clk pulse starting a block transmission; ignored while wbusy=1
- wbusy  out  1  1 from the cycle after an accepted wstart until wdone
- wdone  out  1  one-clk pulse when the transfer finishes (any outcome)
- wstat  out  2  result, valid at wdone and held: 0 = accepted, 1 = CRC error token, 2 = write-error token or bad token, 3 = timeout
- inreq  out  1  one-clk pulse requesting a sector byte
- inaddr  out  9  byte address 0..511, valid with inreq
- inbyte  in  8  requested byte, valid exactly 1 clk after inreq (RAM read latency 1)

Behaviour:
- Reset values: sddat0_oe=0, sddat0_out=1, wbusy=0, wdone=0, wstat=0, inreq=0, inaddr=0. FSM=IDLE, CRC=0, counters=0.
- Reset takes effect immediately, including mid-transfer; DAT0 is released at once.
- sdclkl is a registered copy of sdclk.
  - fall = sdclkl & ~sdclk: drive updates happen only on fall.
  - rise = ~sdclkl & sdclk: sampling happens only on rise.
- IDLE: on wstart, go to PRE. Issue inreq with inaddr=0 the same cycle. Capture inbyte into the prefetch register on the next clk.
- PRE: on each fall, drive oe=1 and out=1. After PRE_BITS falls, go to START.
- START: next fall drives 0. Load the shift register from prefetch. Issue inreq for address 1.
- DATA: each fall drives the shift-register MSB, shifts it, and clocks the same bit into the CRC16.
  - On the fall of bit 7 of byte n, load the shift register from prefetch for the next byte.
  - On that same fall, issue inreq for byte n+2, up to address 511.
  - After bit 4095 is driven, go to CRC.
- CRC16: CCITT polynomial x^16+x^12+x^5+1, init 0x0000, data MSB-first per byte.
  - CRC: 16 falls drive the CRC value MSB-first. The CRC register is frozen during this phase.
  - END: one fall drives 1.
  - On the next fall, set oe=0 and go to STAT.
- STAT: on each rise, sample sddat0_in.
  - Wait for the start bit 0, then collect 3 token bits, then the end bit.
  - Token 010 → BUSY. Token 101 → wstat=1. Any other token → wstat=2. Both failure cases go to FIN.
  - A missing end bit (sampled 0) → wstat=2.
- BUSY: on each rise, if sddat0_in=1, go to FIN with wstat=0.
- Timeout: one counter counts rises through STAT and BUSY. If it exceeds BUSY_TIMEOUT → wstat=3, go to FIN.
- FIN: one-clk wdone pulse, clear wbusy, return to IDLE.
- A wstart in the same cycle as wdone is ignored.
- oe=1 only during PRE..END; the line is never driven in STAT, BUSY or IDLE.

Decomposition:
- Shared header sd_defs.vh holds:
  - FSM state codes (IDLE, PRE, START, DATA, CRC, END, STAT, BUSY, FIN);
  - wstat codes;
  - token constants 3'b010 and 3'b101.
- One sub-module, sd_crc16: bit-serial, with ports clk, rst, clr, en, din, crc[15:0]. It is reused later for read-CRC checking.

Test Plan:
- 512 bytes of 0xFF, card model answers token 010 then holds busy 100 rises → DAT0 carries start 0, 4096 ones, CRC 0x7FA1, end 1; wstat=0; wdone after busy releases.
- Data inbyte = address[7:0] → captured stream matches bytes 0x00..0xFF repeated twice; exactly 512 inreq pulses with inaddr 0..511 in order; CRC matches the model's software CRC16.
- Card model returns token 101 → wstat=1, wdone within 2 clk of the end-bit rise, oe stays 0 from END onward.
- Card holds DAT0 low forever, BUSY_TIMEOUT=1000 in the bench → wstat=3 after 1001 rises; the next wstart starts a fresh transfer.
- Assert rst mid-DATA at byte 100 → oe=0 and wbusy=0 on the same edge; a following wstart restarts from inaddr=0 with CRC init 0.
- wstart pulsed while wbusy=1, and again in the wdone cycle → both ignored; exactly one transfer occurs.
